// File: rtl/branch_resolve.sv
// Branch resolution stage at the EX/MEM boundary.
// Computes the real next PC of each control-flow instruction and compares it
// with the fetch prediction. On a mispredict it issues a one-cycle redirect and
// a multi-cycle squash of the younger wrong-path stages. It also emits one
// predictor update per resolved instruction.
// Optional feature: define BRANCH_RESOLVE_PERF_EN to build saturating
// resolved/mispredict performance counters. Without the macro, both perf
// ports are tied to zero.
module branch_resolve #(
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic        ex_br_en,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        squash,
  output logic        misalign,
  output logic        bp_upd_valid,
  output logic [31:0] bp_upd_pc,
  output logic        bp_upd_taken,
  output logic [31:0] bp_upd_target,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_mispred_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    SQUASH
  } state_e;

  localparam logic [2:0] SquashLoad = 3'(SQUASH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirectPc_q, redirectPc_d;
  logic        squash_q, squash_d;
  logic        misalign_q, misalign_d;
  logic        updValid_q, updValid_d;
  logic [31:0] updPc_q, updPc_d;
  logic        updTaken_q, updTaken_d;
  logic [31:0] updTarget_q, updTarget_d;

  logic        isCtrl;
  logic        sample;
  logic        taken;
  logic [31:0] pcImm;
  logic [31:0] jalrSum;
  logic [31:0] target;
  logic [31:0] nextPc;
  logic        mispredict;

  assign pcImm   = ex_pc + ex_imm;
  assign jalrSum = ex_rs1 + ex_imm;

  // Decode the instruction in EX into direction, target and mispredict status
  always_comb begin
    isCtrl     = ex_is_br | ex_is_jal | ex_is_jalr;
    sample     = ex_valid & ~stall & (state_q == IDLE) & isCtrl;
    taken      = ex_is_jal | ex_is_jalr | (ex_is_br & ex_br_en);
    target     = ex_is_jalr ? (jalrSum & ~32'd1) : pcImm;
    nextPc     = taken ? target : (ex_pc + 32'd4);
    mispredict = (ex_pred_taken != taken) | (taken & (ex_pred_target != target));
  end

  // Next-state and next-output logic; pulses default low, data outputs hold
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    redirect_d   = 1'b0;
    redirectPc_d = redirectPc_q;
    squash_d     = 1'b0;
    misalign_d   = 1'b0;
    updValid_d   = 1'b0;
    updPc_d      = updPc_q;
    updTaken_d   = updTaken_q;
    updTarget_d  = updTarget_q;
    case (state_q)
      IDLE: begin
        if (sample) begin
          updValid_d  = 1'b1;
          updPc_d     = ex_pc;
          updTaken_d  = taken;
          updTarget_d = target;
          misalign_d  = taken & target[1];
          if (mispredict) begin
            state_d      = REDIRECT;
            redirect_d   = 1'b1;
            redirectPc_d = nextPc;
            squash_d     = 1'b1;
          end
        end
      end
      REDIRECT: begin
        cnt_d = SquashLoad;
        if (SquashLoad != 3'd0) begin
          state_d  = SQUASH;
          squash_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SQUASH: begin
        squash_d = 1'b1;
        if (!stall) begin
          if (cnt_q == 3'd1) begin
            state_d  = IDLE;
            squash_d = 1'b0;
            cnt_d    = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, squash counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      redirect_q   <= 1'b0;
      redirectPc_q <= 32'd0;
      squash_q     <= 1'b0;
      misalign_q   <= 1'b0;
      updValid_q   <= 1'b0;
      updPc_q      <= 32'd0;
      updTaken_q   <= 1'b0;
      updTarget_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      redirect_q   <= redirect_d;
      redirectPc_q <= redirectPc_d;
      squash_q     <= squash_d;
      misalign_q   <= misalign_d;
      updValid_q   <= updValid_d;
      updPc_q      <= updPc_d;
      updTaken_q   <= updTaken_d;
      updTarget_q  <= updTarget_d;
    end
  end

  assign redirect      = redirect_q;
  assign redirect_pc   = redirectPc_q;
  assign squash        = squash_q;
  assign misalign      = misalign_q;
  assign bp_upd_valid  = updValid_q;
  assign bp_upd_pc     = updPc_q;
  assign bp_upd_taken  = updTaken_q;
  assign bp_upd_target = updTarget_q;

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] perfBrCnt_q;
  logic [31:0] perfMispredCnt_q;

  // Saturating counters of resolved and mispredicted control-flow instructions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfBrCnt_q      <= 32'd0;
      perfMispredCnt_q <= 32'd0;
    end else begin
      if (sample && (perfBrCnt_q != 32'hFFFF_FFFF)) begin
        perfBrCnt_q <= perfBrCnt_q + 32'd1;
      end
      if (sample && mispredict && (perfMispredCnt_q != 32'hFFFF_FFFF)) begin
        perfMispredCnt_q <= perfMispredCnt_q + 32'd1;
      end
    end
  end

  assign perf_br_cnt      = perfBrCnt_q;
  assign perf_mispred_cnt = perfMispredCnt_q;
`else
  assign perf_br_cnt      = 32'd0;
  assign perf_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
// Inputs change on the falling edge and outputs are checked 1 ns after the
// rising edge. The expected values are worked out by hand for each vector.
module tb_branch_resolve;

`ifdef BRANCH_RESOLVE_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_br;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        ex_br_en;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        squash;
  logic        misalign;
  logic        bp_upd_valid;
  logic [31:0] bp_upd_pc;
  logic        bp_upd_taken;
  logic [31:0] bp_upd_target;
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mispred_cnt;

  int testsRun;
  int testsFailed;

  branch_resolve #(.SQUASH_CYCLES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_valid         (ex_valid),
    .ex_is_br         (ex_is_br),
    .ex_is_jal        (ex_is_jal),
    .ex_is_jalr       (ex_is_jalr),
    .ex_br_en         (ex_br_en),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .ex_rs1           (ex_rs1),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .squash           (squash),
    .misalign         (misalign),
    .bp_upd_valid     (bp_upd_valid),
    .bp_upd_pc        (bp_upd_pc),
    .bp_upd_taken     (bp_upd_taken),
    .bp_upd_target    (bp_upd_target),
    .perf_br_cnt      (perf_br_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive idle, non-control inputs
  task automatic clearInputs();
    ex_valid       = 1'b0;
    ex_is_br       = 1'b0;
    ex_is_jal      = 1'b0;
    ex_is_jalr     = 1'b0;
    ex_br_en       = 1'b0;
    ex_pc          = 32'd0;
    ex_imm         = 32'd0;
    ex_rs1         = 32'd0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'd0;
  endtask

  // Present one valid control-flow instruction in EX
  task automatic applyStimulus(input logic br, input logic jal, input logic jalr,
                               input logic brEn, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] rs1,
                               input logic predTaken, input logic [31:0] predTarget);
    ex_valid       = 1'b1;
    ex_is_br       = br;
    ex_is_jal      = jal;
    ex_is_jalr     = jalr;
    ex_br_en       = brEn;
    ex_pc          = pc;
    ex_imm         = imm;
    ex_rs1         = rs1;
    ex_pred_taken  = predTaken;
    ex_pred_target = predTarget;
  endtask

  // Advance to just after the next rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    stall       = 1'b0;
    clearInputs();
    rst = 1'b0;
    #12;
    checkOutput("reset_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("reset_squash", {31'd0, squash}, 32'd0);
    checkOutput("reset_upd_valid", {31'd0, bp_upd_valid}, 32'd0);
    checkOutput("reset_perf_br", perf_br_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // BEQ pc=0x100 imm=0x20 taken, predicted not taken -> mispredict to 0x120
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h20, 32'h0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("beq_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("beq_redirect_pc", redirect_pc, 32'h120);
    checkOutput("beq_squash", {31'd0, squash}, 32'd1);
    checkOutput("beq_upd_valid", {31'd0, bp_upd_valid}, 32'd1);
    checkOutput("beq_upd_pc", bp_upd_pc, 32'h100);
    checkOutput("beq_upd_taken", {31'd0, bp_upd_taken}, 32'd1);
    checkOutput("beq_upd_target", bp_upd_target, 32'h120);
    checkOutput("beq_misalign", {31'd0, misalign}, 32'd0);
    checkOutput("beq_perf_br", perf_br_cnt, PerfEn ? 32'd1 : 32'd0);
    checkOutput("beq_perf_mis", perf_mispred_cnt, PerfEn ? 32'd1 : 32'd0);
    @(negedge clk);
    clearInputs();
    stepCycle();
    checkOutput("beq_squash2", {31'd0, squash}, 32'd1);
    checkOutput("beq_redirect2", {31'd0, redirect}, 32'd0);
    checkOutput("beq_upd_valid2", {31'd0, bp_upd_valid}, 32'd0);
    stepCycle();
    checkOutput("beq_squash_end", {31'd0, squash}, 32'd0);

    // BNE pc=0x200 imm=0x40 not taken, predicted not taken: no redirect
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0, 1'b0, 32'hDEAD);
    stepCycle();
    checkOutput("bne_upd_valid", {31'd0, bp_upd_valid}, 32'd1);
    checkOutput("bne_upd_taken", {31'd0, bp_upd_taken}, 32'd0);
    checkOutput("bne_upd_target", bp_upd_target, 32'h240);
    checkOutput("bne_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("bne_squash", {31'd0, squash}, 32'd0);
    checkOutput("bne_redirect_pc_hold", redirect_pc, 32'h120);

    // JALR rs1=0x1003 imm=4 -> 0x1006, correctly predicted, bit 1 set
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h4, 32'h1003, 1'b1, 32'h1006);
    stepCycle();
    checkOutput("jalr_upd_target", bp_upd_target, 32'h1006);
    checkOutput("jalr_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("jalr_misalign", {31'd0, misalign}, 32'd1);
    checkOutput("jalr_upd_taken", {31'd0, bp_upd_taken}, 32'd1);

    // Stall in IDLE: the branch is not sampled and the pulses do not stretch
    @(negedge clk);
    stall = 1'b1;
    stepCycle();
    checkOutput("stall_upd_valid", {31'd0, bp_upd_valid}, 32'd0);
    checkOutput("stall_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    stall = 1'b0;
    clearInputs();

    // JAL pc=0x300 imm=0x100 predicted not taken -> redirect to 0x400
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h100, 32'h0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("jal_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("jal_redirect_pc", redirect_pc, 32'h400);
    checkOutput("jal_perf_br", perf_br_cnt, PerfEn ? 32'd4 : 32'd0);
    checkOutput("jal_perf_mis", perf_mispred_cnt, PerfEn ? 32'd2 : 32'd0);
    // Stall for three cycles with a wrong-path branch sitting in EX
    @(negedge clk);
    stall = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 32'h8, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("jal_stall_squash", {31'd0, squash}, 32'd1);
      checkOutput("jal_stall_upd_valid", {31'd0, bp_upd_valid}, 32'd0);
    end
    @(negedge clk);
    stall = 1'b0;
    stepCycle();
    checkOutput("jal_squash_drop", {31'd0, squash}, 32'd0);
    checkOutput("jal_wrongpath_upd", {31'd0, bp_upd_valid}, 32'd0);
    checkOutput("jal_wrongpath_redirect", {31'd0, redirect}, 32'd0);
    @(negedge clk);
    clearInputs();

    // Mispredict, then reset asynchronously while squashing
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h600, 32'h10, 32'h0, 1'b0, 32'h0);
    stepCycle();
    @(negedge clk);
    clearInputs();
    stepCycle();
    checkOutput("pre_rst_squash", {31'd0, squash}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_squash", {31'd0, squash}, 32'd0);
    checkOutput("midrst_redirect_pc", redirect_pc, 32'd0);
    checkOutput("midrst_upd_pc", bp_upd_pc, 32'd0);
    checkOutput("midrst_perf_mis", perf_mispred_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h700, 32'h10, 32'h0, 1'b1, 32'h710);
    stepCycle();
    checkOutput("postrst_upd_valid", {31'd0, bp_upd_valid}, 32'd1);
    checkOutput("postrst_upd_target", bp_upd_target, 32'h710);
    checkOutput("postrst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("postrst_perf_br", perf_br_cnt, PerfEn ? 32'd1 : 32'd0);
    @(negedge clk);
    clearInputs();

`ifdef BRANCH_RESOLVE_PERF_EN
    // Saturation: preload the resolved counter to all ones, then resolve one more
    @(negedge clk);
    force dut.perfBrCnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.perfBrCnt_q;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h800, 32'h10, 32'h0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("perf_saturate", perf_br_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    clearInputs();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
